// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH iterations per product, fixed latency.
// Define MULT_SIGNED_EN to enable signed (MULT) operation via sign-magnitude.
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | one shift-add step per cycle, busy=1 stalls the pipeline
// DONE  | result valid, mult_finish pulse; may accept a new start
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 flush,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     srcA,
    input  logic [WIDTH-1:0]     srcB,
    output logic                 busy,
    output logic                 mult_finish,
    output logic [2*WIDTH-1:0]   mult_result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_count;
    logic [WIDTH-1:0]      r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic [2*WIDTH-1:0]    r_acc;

    logic [WIDTH-1:0]      w_a_mag;
    logic [WIDTH-1:0]      w_b_mag;
    logic [WIDTH:0]        w_sum;
    logic [2*WIDTH-1:0]    w_acc_next;
    logic [2*WIDTH-1:0]    w_product;
    logic                  w_accept;
    logic                  w_last;

    assign w_accept = start && !flush && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_state == BUSY) && (r_count == CNT_W'(WIDTH - 1));

    // Upper WIDTH+1 bits take the add; the carry lands in the MSB after the shift.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

`ifdef MULT_SIGNED_EN
    logic r_negate;
    logic w_a_neg;
    logic w_b_neg;

    // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign w_a_neg   = is_signed && srcA[WIDTH-1];
    assign w_b_neg   = is_signed && srcB[WIDTH-1];
    assign w_a_mag   = w_a_neg ? -srcA : srcA;
    assign w_b_mag   = w_b_neg ? -srcB : srcB;
    assign w_product = r_negate ? -w_acc_next : w_acc_next;
`else
    logic w_unused_is_signed;

    assign w_unused_is_signed = is_signed;
    assign w_a_mag   = srcA;
    assign w_b_mag   = srcB;
    assign w_product = w_acc_next;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = BUSY;
            BUSY:    if (w_last) w_next_state = DONE;
            DONE:    w_next_state = w_accept ? BUSY : IDLE;
            default: w_next_state = IDLE;
        endcase
        if (flush) begin
            w_next_state = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_count     <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            mult_result <= '0;
`ifdef MULT_SIGNED_EN
            r_negate    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_count  <= '0;
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_acc    <= '0;
`ifdef MULT_SIGNED_EN
            r_negate <= w_a_neg ^ w_b_neg;
`endif
        end else if (r_state == BUSY && !flush) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            if (r_count != CNT_W'(WIDTH)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_last) begin
                mult_result <= w_product;
            end
        end
    end

    assign busy        = (r_state == BUSY);
    assign mult_finish = (r_state == DONE) && !flush && !reset;

endmodule
